// File: rtl/scc_pkg.sv
// scc_pkg: shared constants for the SCC wave-RAM access path.
package scc_pkg;
  localparam logic [7:0] SCC_WAVE_END  = 8'h80;
  localparam logic [7:0] SCCI_WAVE_END = 8'hA0;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] BANK_A = 3'd0;
  localparam logic [2:0] BANK_B = 3'd1;
  localparam logic [2:0] BANK_C = 3'd2;
  localparam logic [2:0] BANK_D = 3'd3;
  localparam logic [2:0] BANK_E = 3'd4;
endpackage

// File: rtl/scc_wave_addr_decode.sv
// scc_wave_addr_decode: maps a CPU wave-window offset to wave-RAM bank and address.
module scc_wave_addr_decode
  import scc_pkg::*;
(
  input  logic [7:0] cpu_a,
  input  logic       scci,
  output logic       mapped,
  output logic [2:0] id,
  output logic [4:0] a
);
  assign mapped = cpu_a < (scci ? SCCI_WAVE_END : SCC_WAVE_END);
  assign id = scci ? cpu_a[7:5] : {1'b0, cpu_a[6:5]};
  assign a = cpu_a[4:0];
endmodule

// File: rtl/scc_wave_access_ctrl.sv
// scc_wave_access_ctrl: CPU-side wave-RAM initiator, strobes paced by mixer frames.
module scc_wave_access_ctrl
  import scc_pkg::*;
#(
  parameter int         min_gap_frames = 1,
  parameter logic [7:0] unmapped_q     = 8'hFF
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       reg_scci_enable,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_a,
  input  logic [7:0] cpu_d,
  output logic       cpu_busy,
  output logic       cpu_ack,
  output logic [7:0] cpu_q,
  output logic [2:0] sram_id,
  output logic [4:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_oe,
  output logic       sram_we,
  input  logic [7:0] sram_q,
  input  logic       sram_q_en,
  input  logic [2:0] active
);
  localparam logic [2:0] GAP_MAX = 3'(min_gap_frames);
  logic [2:0] state, gap_cnt, dec_id;
  logic [4:0] dec_a;
  logic       dec_mapped, wr_q, gap_ok;
  scc_wave_addr_decode u_dec (
    .cpu_a  (cpu_a),
    .scci   (reg_scci_enable),
    .mapped (dec_mapped),
    .id     (dec_id),
    .a      (dec_a)
  );
  assign gap_ok = gap_cnt == GAP_MAX;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state    <= ST_IDLE;
      gap_cnt  <= GAP_MAX;
      wr_q     <= 1'b0;
      cpu_busy <= 1'b0;
      cpu_ack  <= 1'b0;
      cpu_q    <= 8'h00;
      sram_id  <= 3'd0;
      sram_a   <= 5'd0;
      sram_d   <= 8'h00;
      sram_oe  <= 1'b0;
      sram_we  <= 1'b0;
    end else begin
      sram_oe <= 1'b0;
      sram_we <= 1'b0;
      cpu_ack <= 1'b0;
      // the strobe cycle restarts the frame count so the next strobe waits a full gap
      gap_cnt <= state == ST_ACCESS ? 3'd0 : (active == 3'd1 && !gap_ok) ? gap_cnt + 3'd1 : gap_cnt;
      case (state)
        ST_IDLE:
          if (cpu_req && dec_mapped) begin
            sram_id  <= dec_id;
            sram_a   <= dec_a;
            sram_d   <= cpu_d;
            wr_q     <= cpu_wr;
            cpu_busy <= 1'b1;
            sram_we  <= gap_ok && cpu_wr;
            sram_oe  <= gap_ok && !cpu_wr;
            state    <= gap_ok ? ST_ACCESS : ST_WAIT;
          end else if (cpu_req) begin
            cpu_q   <= cpu_wr ? cpu_q : unmapped_q;
            cpu_ack <= 1'b1;
            state   <= ST_DONE;
          end
        ST_WAIT:
          if (gap_ok) begin
            sram_we <= wr_q;
            sram_oe <= !wr_q;
            state   <= ST_ACCESS;
          end
        ST_ACCESS: begin
          cpu_ack  <= wr_q;
          cpu_busy <= !wr_q;
          state    <= wr_q ? ST_DONE : ST_CAPTURE;
        end
        ST_CAPTURE:
          if (sram_q_en) begin
            cpu_q    <= sram_q;
            cpu_ack  <= 1'b1;
            cpu_busy <= 1'b0;
            state    <= ST_DONE;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_scc_wave_access_ctrl.sv
// tb_scc_wave_access_ctrl: randomized checks of two controllers (gap 1 and gap 3) against a reference model.
module tb_scc_wave_access_ctrl;
  logic clk = 1'b0, nreset = 1'b0;
  logic [2:0] active = 3'd0;
  logic [1:0] req = '0, wr = '0, scci = '0;
  logic [1:0][7:0] a = '0, d = '0;
  wire [1:0] busy, ack, oe, we, sqen;
  wire [1:0][7:0] q, sd, sq;
  wire [1:0][2:0] sid;
  wire [1:0][4:0] sa;
  logic [7:0] ram [2][256] = '{default: 8'h00};
  logic [7:0] ref_mem [2][256] = '{default: 8'h00};
  logic [7:0] raddr [2] = '{8'h00, 8'h00};
  int pend [2] = '{0, 0};
  int dly [2] = '{1, 1};
  int cyc = 0;
  logic [2:0] act_log [20000];
  int last_s [2] = '{0, 0};
  bit has_s [2] = '{1'b0, 1'b0};
  bit prev_st [2] = '{1'b0, 1'b0};
  int act_since [2] = '{0, 0};
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    scc_wave_access_ctrl #(.min_gap_frames(g == 0 ? 1 : 3), .unmapped_q(8'hFF)) dut (
      .clk(clk), .nreset(nreset), .reg_scci_enable(scci[g]), .cpu_req(req[g]), .cpu_wr(wr[g]),
      .cpu_a(a[g]), .cpu_d(d[g]), .cpu_busy(busy[g]), .cpu_ack(ack[g]), .cpu_q(q[g]),
      .sram_id(sid[g]), .sram_a(sa[g]), .sram_d(sd[g]), .sram_oe(oe[g]), .sram_we(we[g]),
      .sram_q(sq[g]), .sram_q_en(sqen[g]), .active(active)
    );
    assign sqen[g] = pend[g] == 1;
    assign sq[g] = ram[g][raddr[g]];
  end

  function automatic int mg(input int i);
    return i == 0 ? 1 : 3;
  endfunction

  // Mixer stand-in: slot counter with random stalls, wave RAM, read data after dly cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    active <= ($urandom_range(0, 3) == 0) ? active : (active == 3'd5 ? 3'd0 : active + 3'd1);
    for (int i = 0; i < 2; i++) begin
      if (we[i]) ram[i][{sid[i], sa[i]}] <= sd[i];
      if (oe[i]) begin
        raddr[i] <= {sid[i], sa[i]};
        pend[i] <= dly[i];
      end else if (pend[i] != 0) pend[i] <= pend[i] - 1;
    end
  end

  // Strobe-shape and frame-gap monitor.
  always @(negedge clk) begin
    if (cyc < 20000) act_log[cyc] = active;
    for (int i = 0; i < 2; i++) begin
      if (!nreset) begin
        has_s[i] = 1'b0;
        prev_st[i] = 1'b0;
      end else begin
        n_cmp++;
        if ((oe[i] && we[i]) || ((oe[i] || we[i]) && prev_st[i])) begin
          n_fail++;
          $display("FAIL strobe_shape inst%0d cyc %0d: oe=%b we=%b prev=%b, required single exclusive strobe", i, cyc, oe[i], we[i], prev_st[i]);
        end
        if (oe[i] || we[i]) begin
          if (has_s[i]) begin
            n_cmp++;
            if (act_since[i] < mg(i)) begin
              n_fail++;
              $display("FAIL frame_gap inst%0d cyc %0d: %0d frames since last strobe, required >= %0d", i, cyc, act_since[i], mg(i));
            end
          end
          has_s[i] = 1'b1;
          last_s[i] = cyc;
          act_since[i] = 0;
        end else if (active == 3'd1) act_since[i]++;
        prev_st[i] = oe[i] || we[i];
      end
    end
  end

  // Earliest strobe cycle: frames counted strictly after the previous strobe, up to two cycles before.
  function automatic int exp_strobe(input int i, input int r, input bit hs, input int s);
    if (!hs) return r + 1;
    for (int t = r + 1; t < r + 200; t++) begin
      int c = 0;
      for (int k = s + 1; k <= t - 2; k++) if (act_log[k] == 3'd1) c++;
      if (c >= mg(i)) return t;
    end
    return -1;
  endfunction

  task automatic access(input int i, input bit w, input logic [7:0] addr, input logic [7:0] data,
                        input bit sc, input int qd, input string tag);
    int r, s0, t_exp, t_st, t_ack, k;
    bit hs, mapped, st_we;
    logic [2:0] st_id;
    logic [4:0] st_a;
    logic [7:0] st_d, got_q;
    k = 0;
    while ((busy[i] || ack[i]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    dly[i] = qd;
    req[i] = 1'b1; wr[i] = w; a[i] = addr; d[i] = data; scci[i] = sc;
    r = cyc; hs = has_s[i]; s0 = last_s[i];
    mapped = addr < (sc ? 8'd160 : 8'd128);
    @(negedge clk);
    req[i] = 1'b0;
    n_cmp++;
    if (busy[i] !== mapped) begin
      n_fail++;
      $display("FAIL %s busy inst%0d: got %b required %b", tag, i, busy[i], mapped);
    end
    t_st = -1; t_ack = -1; st_we = 0; st_id = 0; st_a = 0; st_d = 0; got_q = 0;
    for (k = 0; k < 100 && t_ack < 0; k++) begin
      if ((oe[i] || we[i]) && t_st < 0) begin
        t_st = cyc; st_we = we[i]; st_id = sid[i]; st_a = sa[i]; st_d = sd[i];
      end
      if (ack[i]) begin
        t_ack = cyc;
        got_q = q[i];
        n_cmp++;
        if (busy[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy_at_ack inst%0d: got %b required 0", tag, i, busy[i]);
        end
      end else @(negedge clk);
    end
    n_cmp++;
    if (t_ack < 0) begin
      n_fail++;
      $display("FAIL %s ack_timeout inst%0d: no ack within 100 cycles", tag, i);
      return;
    end
    if (!mapped) begin
      n_cmp++;
      if (t_st != -1 || t_ack != r + 1) begin
        n_fail++;
        $display("FAIL %s unmapped_timing inst%0d: strobe %0d ack %0d, required no strobe and ack %0d", tag, i, t_st, t_ack, r + 1);
      end
      if (!w) begin
        n_cmp++;
        if (got_q !== 8'hFF) begin
          n_fail++;
          $display("FAIL %s unmapped_q inst%0d: got %h required ff", tag, i, got_q);
        end
      end
      return;
    end
    t_exp = exp_strobe(i, r, hs, s0);
    n_cmp++;
    if (t_st != t_exp || st_we != w) begin
      n_fail++;
      $display("FAIL %s strobe inst%0d: cycle %0d we=%b, required cycle %0d we=%b", tag, i, t_st, st_we, t_exp, w);
    end
    n_cmp++;
    if (st_id !== 3'(addr / 32) || st_a !== 5'(addr % 32)) begin
      n_fail++;
      $display("FAIL %s bank_addr inst%0d: got id %0d a %0d required id %0d a %0d", tag, i, st_id, st_a, addr / 32, addr % 32);
    end
    n_cmp++;
    if (t_ack != t_st + (w ? 1 : qd + 1)) begin
      n_fail++;
      $display("FAIL %s ack_latency inst%0d: ack %0d required %0d", tag, i, t_ack, t_st + (w ? 1 : qd + 1));
    end
    if (w) begin
      n_cmp++;
      if (st_d !== data) begin
        n_fail++;
        $display("FAIL %s sram_d inst%0d: got %h required %h", tag, i, st_d, data);
      end
      ref_mem[i][addr] = data;
    end else begin
      n_cmp++;
      if (got_q !== ref_mem[i][addr]) begin
        n_fail++;
        $display("FAIL %s read_data inst%0d @%h: got %h required %h", tag, i, addr, got_q, ref_mem[i][addr]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({busy[i], ack[i], oe[i], we[i], sid[i], sa[i], sd[i], q[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d: got %h required 0", i, {busy[i], ack[i], oe[i], we[i], sid[i], sa[i], sd[i], q[i]});
      end
    end
    nreset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    access(0, 1, 8'h25, 8'h7F, 0, 1, "write_25");
    access(0, 0, 8'h25, 8'h00, 0, 1, "read_25");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v0, v1;
    v0 = 8'($urandom); v1 = 8'($urandom);
    access(0, 1, 8'h40, v0, 0, 1, "b2b_w0");
    access(0, 1, 8'h41, v1, 0, 1, "b2b_w1");
    access(0, 0, 8'h40, 8'h00, 0, 1, "b2b_r0");
    access(0, 0, 8'h41, 8'h00, 0, 2, "b2b_r1");
  endtask

  task automatic test_map();
    access(0, 0, 8'h85, 8'h00, 0, 1, "scc_unmapped_read");
    access(0, 1, 8'h85, 8'hA5, 1, 1, "scci_write_85");
    access(0, 0, 8'h85, 8'h00, 1, 1, "scci_read_85");
    access(0, 1, 8'h7F, 8'h3C, 0, 1, "scc_edge_7f");
    access(0, 1, 8'h80, 8'h11, 0, 1, "scc_edge_80");
    access(0, 1, 8'h9F, 8'hC3, 1, 1, "scci_edge_9f");
    access(0, 1, 8'hA0, 8'h22, 1, 1, "scci_edge_a0");
    access(0, 0, 8'hA0, 8'h00, 1, 1, "scci_read_a0");
    access(0, 0, 8'h9F, 8'h00, 1, 3, "scci_read_9f");
  endtask

  task automatic test_reset_mid();
    access(1, 1, 8'h10, 8'h33, 1, 1, "pre_reset_w");
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; a[1] = 8'h10; d[1] = 8'h55; scci[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    n_cmp++;
    if (busy[1] !== 1'b1 || we[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_slot inst1: busy=%b we=%b required busy=1 we=0", busy[1], we[1]);
    end
    #2 nreset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({busy[i], ack[i], oe[i], we[i], sid[i], sa[i], sd[i], q[i]} !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_outputs inst%0d: got %h required 0", i, {busy[i], ack[i], oe[i], we[i], sid[i], sa[i], sd[i], q[i]});
      end
    end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      n_cmp++;
      if (oe[1] || we[1] || ack[1] || busy[1]) begin
        n_fail++;
        $display("FAIL lost_request inst1 cyc %0d: oe=%b we=%b ack=%b busy=%b required all 0", cyc, oe[1], we[1], ack[1], busy[1]);
      end
    end
    access(1, 0, 8'h10, 8'h00, 1, 1, "post_reset_read");
  endtask

  task automatic test_gap3();
    access(1, 1, 8'h01, 8'h5A, 0, 1, "gap3_w0");
    access(1, 1, 8'h22, 8'hA5, 0, 1, "gap3_w1");
    access(1, 1, 8'h63, 8'h96, 0, 1, "gap3_w2");
    access(1, 0, 8'h01, 8'h00, 0, 1, "gap3_r0");
    access(1, 0, 8'h22, 8'h00, 0, 2, "gap3_r1");
    access(1, 0, 8'h63, 8'h00, 0, 1, "gap3_r2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int i, qd;
      bit w, sc;
      logic [7:0] addr;
      i = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, sc ? 159 : 127));
      qd = $urandom_range(1, 3);
      access(i, w, addr, 8'($urandom), sc, qd, "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_map();
    test_reset_mid();
    test_gap3();
    test_random();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
